// File: rtl/led_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// led_cmd_parser_pkg
// Shared definitions for the LED command parser:
//   - ASCII codes recognised by the parser and used in responses
//   - parser state encoding
//   - response kinds and response lengths
//   - small character-class helpers
// -----------------------------------------------------------------------------
package led_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_L_UP  = 8'h4C;  // 'L'
  localparam logic [7:0] ASCII_L_LO  = 8'h6C;  // 'l'
  localparam logic [7:0] ASCII_QMARK = 8'h3F;  // '?'
  localparam logic [7:0] ASCII_O     = 8'h4F;  // 'O'
  localparam logic [7:0] ASCII_K     = 8'h4B;  // 'K'
  localparam logic [7:0] ASCII_E     = 8'h45;  // 'E'
  localparam logic [7:0] ASCII_R     = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L_HI    = 3'd1,
    ST_L_LO    = 3'd2,
    ST_L_EOL   = 3'd3,
    ST_Q_EOL   = 3'd4,
    ST_DISCARD = 3'd5,
    ST_RESP    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK    = 2'd0,
    RESP_ER    = 2'd1,
    RESP_QUERY = 2'd2
  } resp_e;

  localparam int         RESP_BUF_DEPTH = 5;
  localparam logic [2:0] RESP_LEN_SHORT = 3'd4;  // "OK\r\n" / "ER\r\n"
  localparam logic [2:0] RESP_LEN_QUERY = 3'd5;  // "Lhh\r\n"

  // Largest value accepted by the set command (six LEDs).
  localparam logic [7:0] LED_MAX_VALUE = 8'h3F;

  function automatic logic is_eol(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

  function automatic logic is_l_cmd(input logic [7:0] c);
    return (c == ASCII_L_UP) || (c == ASCII_L_LO);
  endfunction

endpackage

// File: rtl/led_cmd_parser_ascii_hex.sv
// -----------------------------------------------------------------------------
// ascii_hex
// Purely combinational ASCII <-> hex nibble conversion.
// Ports:
//   char_i          8-bit ASCII character to decode
//   nibble_o        decoded nibble (0 when not a hex digit)
//   nibble_valid_o  1 when char_i is 0-9, A-F or a-f
//   enc_nibble_i    two nibbles to encode ([1] = upper digit)
//   enc_char_o      uppercase ASCII digits for enc_nibble_i
// -----------------------------------------------------------------------------
module ascii_hex (
  input  logic [7:0]      char_i,
  output logic [3:0]      nibble_o,
  output logic            nibble_valid_o,
  input  logic [1:0][3:0] enc_nibble_i,
  output logic [1:0][7:0] enc_char_o
);

  // Returns {valid, nibble}.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] diff;
    diff = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      diff = c - 8'h30;
      return {1'b1, diff[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      diff = c - 8'h37;
      return {1'b1, diff[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      diff = c - 8'h57;
      return {1'b1, diff[3:0]};
    end
    return 5'b0_0000;
  endfunction

  function automatic logic [7:0] hex_encode(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  logic [4:0] dec;

  assign dec            = hex_decode(char_i);
  assign nibble_o       = dec[3:0];
  assign nibble_valid_o = dec[4];

  for (genvar gi = 0; gi < 2; gi++) begin : g_enc
    assign enc_char_o[gi] = hex_encode(enc_nibble_i[gi]);
  end

endmodule

// File: rtl/led_cmd_parser.sv
// -----------------------------------------------------------------------------
// led_cmd_parser
// Line-oriented ASCII command parser for the six on-board LEDs.
//   "Lhh<EOL>" sets the LEDs (value <= 0x3F) and answers "OK\r\n".
//   "?<EOL>"   answers 'L', two uppercase hex digits, "\r\n".
//   Anything else answers "ER\r\n".
// EOL is CR or LF; an EOL while idle is ignored so CRLF gives one answer.
// Ports:
//   clk_pin   system clock
//   rst_pin   synchronous active-high reset
//   rx_valid  one-cycle strobe, rx_data holds a received byte
//   rx_data   received byte
//   tx_valid  tx_data holds a byte to send
//   tx_ready  transmitter accepts (transfer on tx_valid && tx_ready)
//   tx_data   byte to send
//   led_pins  LED drive, inverted when LED_ACTIVE_LOW
//   overrun   sticky: a byte arrived while a response was being sent
// -----------------------------------------------------------------------------
module led_cmd_parser
  import led_cmd_parser_pkg::*;
#(
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_pin,
  input  logic       rst_pin,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [5:0] led_pins,
  output logic       overrun
);

  state_e     state_q;
  logic [3:0] hi_q;
  logic [7:0] val_q;
  logic [5:0] led_state_q;
  logic [2:0] idx_q;
  logic [2:0] len_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       overrun_q;
  logic [7:0] resp_buf_q [RESP_BUF_DEPTH];

  logic [3:0]      rx_nibble;
  logic            rx_is_hex;
  logic [1:0][3:0] enc_nibble;
  logic [1:0][7:0] enc_char;

  logic       resp_fire_d;
  resp_e      resp_kind_d;
  logic [7:0] resp_bytes_d [RESP_BUF_DEPTH];
  logic [2:0] resp_len_d;
  logic [2:0] idx_d;

  ascii_hex u_ascii_hex (
    .char_i         (rx_data),
    .nibble_o       (rx_nibble),
    .nibble_valid_o (rx_is_hex),
    .enc_nibble_i   (enc_nibble),
    .enc_char_o     (enc_char)
  );

  // The query answer is built from led_state as it stands at the EOL cycle.
  assign enc_nibble[1] = {2'b00, led_state_q[5:4]};
  assign enc_nibble[0] = led_state_q[3:0];

  // Which response (if any) the current byte completes.
  always_comb begin
    resp_fire_d = 1'b0;
    resp_kind_d = RESP_ER;
    if (rx_valid && is_eol(rx_data)) begin
      case (state_q)
        ST_L_HI, ST_L_LO, ST_DISCARD: begin
          resp_fire_d = 1'b1;
          resp_kind_d = RESP_ER;
        end
        ST_L_EOL: begin
          resp_fire_d = 1'b1;
          resp_kind_d = (val_q > LED_MAX_VALUE) ? RESP_ER : RESP_OK;
        end
        ST_Q_EOL: begin
          resp_fire_d = 1'b1;
          resp_kind_d = RESP_QUERY;
        end
        default: begin
          resp_fire_d = 1'b0;
          resp_kind_d = RESP_ER;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < RESP_BUF_DEPTH; i++) begin
      resp_bytes_d[i] = 8'h00;
    end
    resp_len_d = RESP_LEN_SHORT;
    case (resp_kind_d)
      RESP_OK: begin
        resp_bytes_d[0] = ASCII_O;
        resp_bytes_d[1] = ASCII_K;
        resp_bytes_d[2] = ASCII_CR;
        resp_bytes_d[3] = ASCII_LF;
      end
      RESP_QUERY: begin
        resp_bytes_d[0] = ASCII_L_UP;
        resp_bytes_d[1] = enc_char[1];
        resp_bytes_d[2] = enc_char[0];
        resp_bytes_d[3] = ASCII_CR;
        resp_bytes_d[4] = ASCII_LF;
        resp_len_d      = RESP_LEN_QUERY;
      end
      default: begin
        resp_bytes_d[0] = ASCII_E;
        resp_bytes_d[1] = ASCII_R;
        resp_bytes_d[2] = ASCII_CR;
        resp_bytes_d[3] = ASCII_LF;
      end
    endcase
  end

  // Response buffer: loaded once per response, read by the sender.
  for (genvar gi = 0; gi < RESP_BUF_DEPTH; gi++) begin : g_resp_buf
    always_ff @(posedge clk_pin) begin
      if (rst_pin) begin
        resp_buf_q[gi] <= 8'h00;
      end else if (resp_fire_d) begin
        resp_buf_q[gi] <= resp_bytes_d[gi];
      end
    end
  end

  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      state_q     <= ST_IDLE;
      hi_q        <= 4'h0;
      val_q       <= 8'h00;
      led_state_q <= 6'h00;
      idx_q       <= 3'd0;
      len_q       <= 3'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
    end else if (state_q == ST_RESP) begin
      // Input is not parsed while answering; any byte is lost.
      if (rx_valid) begin
        overrun_q <= 1'b1;
      end
      if (tx_valid_q && tx_ready) begin
        if (idx_q == len_q - 3'd1) begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
          idx_q      <= 3'd0;
        end else begin
          idx_q     <= idx_d;
          tx_data_q <= resp_buf_q[idx_d];
        end
      end
    end else if (resp_fire_d) begin
      // First byte goes out straight from the freshly built response so it
      // is valid on the cycle after EOL.
      state_q    <= ST_RESP;
      idx_q      <= 3'd0;
      len_q      <= resp_len_d;
      tx_valid_q <= 1'b1;
      tx_data_q  <= resp_bytes_d[0];
      if (resp_kind_d == RESP_OK) begin
        led_state_q <= val_q[5:0];
      end
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_l_cmd(rx_data)) begin
            state_q <= ST_L_HI;
          end else if (rx_data == ASCII_QMARK) begin
            state_q <= ST_Q_EOL;
          end else if (is_eol(rx_data)) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DISCARD;
          end
        end
        ST_L_HI: begin
          if (rx_is_hex) begin
            hi_q    <= rx_nibble;
            state_q <= ST_L_LO;
          end else begin
            state_q <= ST_DISCARD;
          end
        end
        ST_L_LO: begin
          if (rx_is_hex) begin
            val_q   <= {hi_q, rx_nibble};
            state_q <= ST_L_EOL;
          end else begin
            state_q <= ST_DISCARD;
          end
        end
        ST_L_EOL, ST_Q_EOL, ST_DISCARD: begin
          state_q <= ST_DISCARD;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign overrun  = overrun_q;
  assign led_pins = LED_ACTIVE_LOW ? ~led_state_q : led_state_q;

endmodule

// File: tb/tb_led_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_led_cmd_parser
// Directed bench for led_cmd_parser (active-low LEDs). Each step sends a
// command line and checks LEDs, response bytes and overrun against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_led_cmd_parser;

  logic       clk_pin;
  logic       rst_pin;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [5:0] led_pins;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  led_cmd_parser #(.LED_ACTIVE_LOW(1'b1)) dut (
    .clk_pin  (clk_pin),
    .rst_pin  (rst_pin),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .led_pins (led_pins),
    .overrun  (overrun)
  );

  initial clk_pin = 1'b0;
  always #5 clk_pin = ~clk_pin;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for exactly one clock; returns 1 time unit after the
  // edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_pin);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk_pin);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  // Collect a response with tx_ready high and compare byte by byte.
  task automatic expect_resp(input string tag, input string s);
    int waited;
    for (int i = 0; i < s.len(); i++) begin
      waited = 0;
      while (!tx_valid && waited < 50) begin
        @(posedge clk_pin);
        #1;
        waited++;
      end
      check($sformatf("%s tx_valid[%0d]", tag, i), {31'd0, tx_valid}, 32'd1);
      check($sformatf("%s tx_data[%0d]", tag, i), {24'd0, tx_data}, {24'd0, s[i]});
      $display("%s: tx byte %0d = %02h", tag, i, tx_data);
      @(posedge clk_pin);
      #1;
    end
    check($sformatf("%s done", tag), {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    rst_pin  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk_pin);
    #1;
    rst_pin = 1'b0;

    // Reset state
    check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst tx_data", {24'd0, tx_data}, 32'h00);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst led_pins", {26'd0, led_pins}, 32'h3F);

    // L2A CR -> LEDs 0x2A, OK; trailing LF while idle gives nothing
    send_str("L2A\r");
    check("L2A led_pins", {26'd0, led_pins}, 32'h15);
    expect_resp("L2A", "OK\r\n");
    send_byte(8'h0A);
    repeat (3) begin
      check("LF ignored tx_valid", {31'd0, tx_valid}, 32'd0);
      @(posedge clk_pin);
      #1;
    end
    check("after L2A overrun", {31'd0, overrun}, 32'd0);

    send_str("?\n");
    expect_resp("query 2A", "L2A\r\n");

    send_str("L40\n");
    check("L40 led_pins", {26'd0, led_pins}, 32'h15);
    expect_resp("L40", "ER\r\n");
    send_str("Lg1\n");
    expect_resp("Lg1", "ER\r\n");
    send_str("X\n");
    expect_resp("X", "ER\r\n");
    send_str("L5\n");
    expect_resp("L5", "ER\r\n");
    check("after errors led_pins", {26'd0, led_pins}, 32'h15);

    send_str("l3f\r");
    check("l3f led_pins", {26'd0, led_pins}, 32'h00);
    expect_resp("l3f", "OK\r\n");

    // Back-pressure with an injected byte during the response
    tx_ready = 1'b0;
    send_str("L15\n");
    check("L15 led_pins", {26'd0, led_pins}, 32'h2A);
    for (int c = 0; c < 20; c++) begin
      check("stall tx_valid", {31'd0, tx_valid}, 32'd1);
      check("stall tx_data", {24'd0, tx_data}, 32'h4F);
      rx_valid = (c == 5);
      rx_data  = (c == 5) ? 8'h58 : 8'h00;
      @(posedge clk_pin);
      #1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("overrun set", {31'd0, overrun}, 32'd1);
    tx_ready = 1'b1;
    expect_resp("L15", "OK\r\n");
    send_str("?\n");
    expect_resp("query 15", "L15\r\n");
    check("overrun sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-response, with a competing rx byte in the reset cycle
    send_str("?\n");
    check("mid tx byte0", {24'd0, tx_data}, 32'h4C);
    @(posedge clk_pin);
    #1;
    check("mid tx byte1", {24'd0, tx_data}, 32'h31);
    @(posedge clk_pin);
    #1;
    rst_pin  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h4C;
    @(posedge clk_pin);
    #1;
    rst_pin  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("abort tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort led_pins", {26'd0, led_pins}, 32'h3F);
    check("abort overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk_pin);
    #1;
    check("abort no remainder", {31'd0, tx_valid}, 32'd0);
    send_str("?\n");
    expect_resp("query 00", "L00\r\n");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
